// File: rtl/mux_sel_pipe_pkg.sv
// State encodings and small helpers shared by the mux_sel_pipe stage.
// Used by mux_sel_pipe (macro MUX_SEL_PIPE_RANGE_CHECK_EN) and mux_nx1.
package mux_sel_pipe_pkg;

    typedef logic [1:0] pipe_state_t;

    localparam pipe_state_t ST_EMPTY = 2'b00;
    localparam pipe_state_t ST_BUSY  = 2'b01;
    localparam pipe_state_t ST_FULL  = 2'b10;

    function automatic logic sel_out_of_range(input int unsigned sel, input int unsigned num_in);
        return (sel >= num_in);
    endfunction

endpackage

// File: rtl/mux_nx1.sv
// Combinational NUM_IN:1 word selector; any code without a matching input
// falls back to input 0.
module mux_nx1
    import mux_sel_pipe_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] i_data,
    input  logic [SEL_W-1:0]        i_sel,
    output logic [WIDTH-1:0]        o_data
);

    always_comb begin
        o_data = i_data[WIDTH-1:0];
        for (int k = 1; k < NUM_IN; k++) begin
            if (i_sel == SEL_W'(k)) begin
                o_data = i_data[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/mux_sel_pipe.sv
// Registered N:1 operand selector with ready/valid handshake and a two-entry
// skid buffer. Defining MUX_SEL_PIPE_RANGE_CHECK_EN adds the sticky SEL_ERR port.
module mux_sel_pipe
    import mux_sel_pipe_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [NUM_IN*WIDTH-1:0] IN_DATA,
    input  logic [SEL_W-1:0]        SELECT,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    input  logic                    FLUSH,
    output logic [WIDTH-1:0]        OUT_DATA,
    output logic [SEL_W-1:0]        OUT_SEL,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY
`ifdef MUX_SEL_PIPE_RANGE_CHECK_EN
    ,
    output logic                    SEL_ERR
`endif
);

    pipe_state_t       r_state;
    logic [WIDTH-1:0]  r_data_p1;
    logic [SEL_W-1:0]  r_sel_p1;
    logic [WIDTH-1:0]  r_skid_data_p1;
    logic [SEL_W-1:0]  r_skid_sel_p1;

    logic [WIDTH-1:0]  w_sel_data_p0;
    logic              w_in_xfer;
    logic              w_out_xfer;

    mux_nx1 #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_mux (
        .i_data (IN_DATA),
        .i_sel  (SELECT),
        .o_data (w_sel_data_p0)
    );

    // Both ready and valid come straight from the state register, so
    // OUT_READY never reaches IN_READY combinationally.
    assign IN_READY   = (r_state != ST_FULL);
    assign OUT_VALID  = (r_state != ST_EMPTY);
    assign w_in_xfer  = IN_VALID & IN_READY;
    assign w_out_xfer = OUT_VALID & OUT_READY;
    assign OUT_DATA   = r_data_p1;
    assign OUT_SEL    = r_sel_p1;

    // p0 -> p1: main register and state
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= ST_EMPTY;
            r_data_p1 <= '0;
            r_sel_p1  <= '0;
        end else if (FLUSH) begin
            r_state <= ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        r_state   <= ST_BUSY;
                        r_data_p1 <= w_sel_data_p0;
                        r_sel_p1  <= SELECT;
                    end
                end
                ST_BUSY: begin
                    if (w_in_xfer && w_out_xfer) begin
                        r_data_p1 <= w_sel_data_p0;
                        r_sel_p1  <= SELECT;
                    end else if (w_in_xfer) begin
                        r_state <= ST_FULL;
                    end else if (w_out_xfer) begin
                        r_state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_out_xfer) begin
                        r_state   <= ST_BUSY;
                        r_data_p1 <= r_skid_data_p1;
                        r_sel_p1  <= r_skid_sel_p1;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

    // p0 -> p1: skid entry, written only when main is stalled
    always_ff @(posedge CLK) begin
        if (!RESET && !FLUSH && (r_state == ST_BUSY) && w_in_xfer && !w_out_xfer) begin
            r_skid_data_p1 <= w_sel_data_p0;
            r_skid_sel_p1  <= SELECT;
        end
    end

`ifdef MUX_SEL_PIPE_RANGE_CHECK_EN
    logic r_sel_err;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sel_err <= 1'b0;
        end else if (w_in_xfer && sel_out_of_range(32'(SELECT), NUM_IN)) begin
            r_sel_err <= 1'b1;
        end
    end

    assign SEL_ERR = r_sel_err;
`endif

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Scoreboard bench for mux_sel_pipe: three instances (32x4, 64x8, 16x3) driven
// with directed and random traffic against a queue-based occupancy model.
module tb_mux_sel_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- DUT A: 32 bit x 4 inputs ----------------
    logic [127:0] a_in_data = '0;
    logic [1:0]   a_sel = '0;
    logic         a_in_valid = 1'b0, a_in_ready, a_flush = 1'b0;
    logic [31:0]  a_out_data;
    logic [1:0]   a_out_sel;
    logic         a_out_valid, a_out_ready = 1'b1;

    mux_sel_pipe #(.WIDTH(32), .NUM_IN(4)) u_dut_a (
        .CLK(clk), .RESET(rst), .IN_DATA(a_in_data), .SELECT(a_sel),
        .IN_VALID(a_in_valid), .IN_READY(a_in_ready), .FLUSH(a_flush),
        .OUT_DATA(a_out_data), .OUT_SEL(a_out_sel), .OUT_VALID(a_out_valid),
        .OUT_READY(a_out_ready)
`ifdef MUX_SEL_PIPE_RANGE_CHECK_EN
        , .SEL_ERR()
`endif
    );

    // ---------------- DUT B: 64 bit x 8 inputs ----------------
    logic [511:0] b_in_data = '0;
    logic [2:0]   b_sel = '0;
    logic         b_in_valid = 1'b0, b_in_ready, b_flush = 1'b0;
    logic [63:0]  b_out_data;
    logic [2:0]   b_out_sel;
    logic         b_out_valid, b_out_ready = 1'b1;

    mux_sel_pipe #(.WIDTH(64), .NUM_IN(8)) u_dut_b (
        .CLK(clk), .RESET(rst), .IN_DATA(b_in_data), .SELECT(b_sel),
        .IN_VALID(b_in_valid), .IN_READY(b_in_ready), .FLUSH(b_flush),
        .OUT_DATA(b_out_data), .OUT_SEL(b_out_sel), .OUT_VALID(b_out_valid),
        .OUT_READY(b_out_ready)
`ifdef MUX_SEL_PIPE_RANGE_CHECK_EN
        , .SEL_ERR()
`endif
    );

    // ---------------- DUT C: 16 bit x 3 inputs (non power of two) ----------------
    logic [47:0]  c_in_data = '0;
    logic [1:0]   c_sel = '0;
    logic         c_in_valid = 1'b0, c_in_ready, c_flush = 1'b0;
    logic [15:0]  c_out_data;
    logic [1:0]   c_out_sel;
    logic         c_out_valid, c_out_ready = 1'b1;
`ifdef MUX_SEL_PIPE_RANGE_CHECK_EN
    logic         c_sel_err;
    logic         c_err_m = 1'b0;
`endif

    mux_sel_pipe #(.WIDTH(16), .NUM_IN(3)) u_dut_c (
        .CLK(clk), .RESET(rst), .IN_DATA(c_in_data), .SELECT(c_sel),
        .IN_VALID(c_in_valid), .IN_READY(c_in_ready), .FLUSH(c_flush),
        .OUT_DATA(c_out_data), .OUT_SEL(c_out_sel), .OUT_VALID(c_out_valid),
        .OUT_READY(c_out_ready)
`ifdef MUX_SEL_PIPE_RANGE_CHECK_EN
        , .SEL_ERR(c_sel_err)
`endif
    );

    // Scoreboards: each queue holds the words the stage should own after the
    // coming clock edge, oldest first; capacity of the stage is two words.
    typedef struct packed { logic [31:0] d; logic [1:0] s; } a_item_t;
    typedef struct packed { logic [63:0] d; logic [2:0] s; } b_item_t;
    typedef struct packed { logic [15:0] d; logic [1:0] s; } c_item_t;
    a_item_t a_q[$];
    b_item_t b_q[$];
    c_item_t c_q[$];
    logic a_zero = 1'b0, b_zero = 1'b0, c_zero = 1'b0;

    always @(negedge clk) begin
        int n0;
        a_item_t it;
        n0 = a_q.size();
        if (a_zero) begin
            chk("A_rst_data", 64'(a_out_data), 64'd0);
            chk("A_rst_sel", 64'(a_out_sel), 64'd0);
        end
        chk("A_in_ready", 64'(a_in_ready), 64'(n0 < 2));
        chk("A_out_valid", 64'(a_out_valid), 64'(n0 != 0));
        if (a_out_valid && n0 != 0) begin
            chk("A_out_data", 64'(a_out_data), 64'(a_q[0].d));
            chk("A_out_sel", 64'(a_out_sel), 64'(a_q[0].s));
            if (a_out_ready) void'(a_q.pop_front());
        end
        if (rst || a_flush) a_q.delete();
        else if (a_in_valid && n0 < 2) begin
            it.d = a_in_data[a_sel*32 +: 32];
            it.s = a_sel;
            a_q.push_back(it);
        end
        a_zero = rst;
    end

    always @(negedge clk) begin
        int n0;
        b_item_t it;
        n0 = b_q.size();
        if (b_zero) begin
            chk("B_rst_data", b_out_data, 64'd0);
            chk("B_rst_sel", 64'(b_out_sel), 64'd0);
        end
        chk("B_in_ready", 64'(b_in_ready), 64'(n0 < 2));
        chk("B_out_valid", 64'(b_out_valid), 64'(n0 != 0));
        if (b_out_valid && n0 != 0) begin
            chk("B_out_data", b_out_data, b_q[0].d);
            chk("B_out_sel", 64'(b_out_sel), 64'(b_q[0].s));
            if (b_out_ready) void'(b_q.pop_front());
        end
        if (rst || b_flush) b_q.delete();
        else if (b_in_valid && n0 < 2) begin
            it.d = b_in_data[b_sel*64 +: 64];
            it.s = b_sel;
            b_q.push_back(it);
        end
        b_zero = rst;
    end

    always @(negedge clk) begin
        int n0;
        c_item_t it;
        n0 = c_q.size();
        if (c_zero) begin
            chk("C_rst_data", 64'(c_out_data), 64'd0);
            chk("C_rst_sel", 64'(c_out_sel), 64'd0);
        end
        chk("C_in_ready", 64'(c_in_ready), 64'(n0 < 2));
        chk("C_out_valid", 64'(c_out_valid), 64'(n0 != 0));
        if (c_out_valid && n0 != 0) begin
            chk("C_out_data", 64'(c_out_data), 64'(c_q[0].d));
            chk("C_out_sel", 64'(c_out_sel), 64'(c_q[0].s));
            if (c_out_ready) void'(c_q.pop_front());
        end
`ifdef MUX_SEL_PIPE_RANGE_CHECK_EN
        chk("C_sel_err", 64'(c_sel_err), 64'(c_err_m));
        if (rst) c_err_m = 1'b0;
        else if (c_in_valid && n0 < 2 && int'(c_sel) >= 3) c_err_m = 1'b1;
`endif
        if (rst || c_flush) c_q.delete();
        else if (c_in_valid && n0 < 2) begin
            it.d = (int'(c_sel) < 3) ? c_in_data[c_sel*16 +: 16] : c_in_data[15:0];
            it.s = c_sel;
            c_q.push_back(it);
        end
        c_zero = rst;
    end

    logic [1:0] stream_sel [3] = '{2'd2, 2'd0, 2'd3};

    initial begin
        step(2);
        rst = 1'b0;

        // Reset then stream on A
        a_in_data = {32'h0000_00D3, 32'h0000_00C2, 32'h0000_00B1, 32'h0000_00A0};
        for (int i = 0; i < 3; i++) begin
            a_in_valid = 1'b1;
            a_sel = stream_sel[i];
            step(1);
        end
        a_in_valid = 1'b0;
        step(3);

        // Back-pressure: four stalled cycles, then drain
        a_out_ready = 1'b0;
        a_in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_in_data = {$urandom, $urandom, $urandom, $urandom};
            a_sel = 2'($urandom);
            step(1);
        end
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        step(3);

        // Flush while full, with a word presented in the flush cycle
        a_out_ready = 1'b0;
        a_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_in_data = {$urandom, $urandom, $urandom, $urandom};
            step(1);
        end
        a_flush = 1'b1;
        step(1);
        a_flush = 1'b0;
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        step(2);

        // Width sweep on B over every select
        for (int k = 0; k < 8; k++) b_in_data[k*64 +: 64] = {$urandom, $urandom};
        b_in_valid = 1'b1;
        for (int s = 0; s < 8; s++) begin
            b_sel = 3'(s);
            step(1);
        end
        b_in_valid = 1'b0;
        step(2);

        // Out-of-range select on the 3-input instance picks input 0
        c_in_data = {16'h5555, 16'hBEEF, 16'h1234};
        c_in_valid = 1'b1;
        c_sel = 2'd3;
        step(1);
        c_in_valid = 1'b0;
        c_sel = 2'd1;
        step(3);

        // Reset while A is full, with an input presented during reset
        a_out_ready = 1'b0;
        a_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_in_data = {$urandom, $urandom, $urandom, $urandom};
            step(1);
        end
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        step(2);

        // Random traffic on all three instances
        for (int i = 0; i < 500; i++) begin
            a_in_valid  = ($urandom_range(0, 9) < 7);
            a_sel       = 2'($urandom);
            a_in_data   = {$urandom, $urandom, $urandom, $urandom};
            a_out_ready = ($urandom_range(0, 9) < 6);
            a_flush     = ($urandom_range(0, 39) == 0);
            b_in_valid  = ($urandom_range(0, 9) < 7);
            b_sel       = 3'($urandom);
            for (int k = 0; k < 8; k++) b_in_data[k*64 +: 64] = {$urandom, $urandom};
            b_out_ready = ($urandom_range(0, 9) < 5);
            b_flush     = ($urandom_range(0, 39) == 0);
            c_in_valid  = ($urandom_range(0, 9) < 7);
            c_sel       = 2'($urandom_range(0, 3));
            c_in_data   = {16'($urandom), 16'($urandom), 16'($urandom)};
            c_out_ready = ($urandom_range(0, 9) < 7);
            c_flush     = ($urandom_range(0, 39) == 0);
            step(1);
        end

        a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0;
        a_flush = 1'b0; b_flush = 1'b0; c_flush = 1'b0;
        a_out_ready = 1'b1; b_out_ready = 1'b1; c_out_ready = 1'b1;
        step(4);
        chk("A_drained", 64'(a_q.size()), 64'd0);
        chk("B_drained", 64'(b_q.size()), 64'd0);
        chk("C_drained", 64'(c_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_sel_pipe.md
# mux_sel_pipe

Parametrised N-input, WIDTH-bit registered selector with a ready/valid handshake and a two-entry skid buffer. It generalises the pipeline's fixed 4:1 32-bit operand muxes into a stallable stage placed between forwarding-select logic and the EX-stage operand latches. The selected word and its select code are registered, and the stage can be flushed. Full throughput is sustained under back-pressure without a combinational ready path.

## Interface
Parameters:
- WIDTH, 32, data width in bits
- NUM_IN, 4, number of data inputs (2..16)
- SEL_W, $clog2(NUM_IN), select width (derived; do not override)

Ports:
- CLK  input  1  rising-edge clock
- RESET  input  1  reset, synchronous, active-high
- IN_DATA  input  NUM_IN*WIDTH  flattened inputs; input k = IN_DATA[k*WIDTH +: WIDTH]
- SELECT  input  SEL_W  input index, sampled with IN_VALID
- IN_VALID  input  1  upstream presents a word
- IN_READY  output  1  stage can accept; registered-state-derived only
- FLUSH  input  1  discard all held words
- OUT_DATA  output  WIDTH  selected word
- OUT_SEL  output  SEL_W  select code that produced OUT_DATA
- OUT_VALID  output  1  OUT_DATA valid
- OUT_READY  input  1  downstream accepts
- SEL_ERR  output  1  sticky range error; present only with the configuration macro

## Operation
- An input transfer occurs when IN_VALID & IN_READY. An output transfer occurs when OUT_VALID & OUT_READY.
- Selected word = input[SELECT] when SELECT < NUM_IN, otherwise input 0.
- Storage: main register (drives outputs) and skid register.
- State machine:
  - EMPTY: no word held.
  - BUSY: main register full.
  - FULL: main and skid registers full.
- IN_READY = (state != FULL).
- Transitions:
  - EMPTY + input transfer -> BUSY.
  - BUSY + input transfer, no output transfer -> FULL; the word goes to skid.
  - BUSY + input transfer + output transfer -> BUSY; main reloads with the new word.
  - BUSY + output transfer only -> EMPTY.
  - FULL + output transfer -> BUSY; skid moves to main.
  - FULL: no input transfer is possible.
- FLUSH has priority over everything. Next state is EMPTY and OUT_VALID = 0. Any input presented in the FLUSH cycle is dropped. An output transfer in the FLUSH cycle still completes downstream.
- OUT_DATA and OUT_SEL hold their last value when OUT_VALID = 0. Data registers are not cleared except by RESET.
- Ordering is strictly FIFO. Nothing is ever duplicated or dropped except on FLUSH or RESET.

## Timing
- Reset values:
  - OUT_VALID = 0
  - OUT_DATA = 0
  - OUT_SEL = 0
  - state = EMPTY, so IN_READY = 1 in the first cycle after RESET deasserts
  - SEL_ERR = 0
- Input transfers in a cycle with RESET high are ignored.
- RESET mid-operation discards both held words.
- Latency: a word accepted at edge n appears with OUT_VALID = 1 after edge n. This is 1 cycle.
- Throughput: 1 word/cycle while OUT_READY stays high.
- Stall: OUT_READY low for k cycles absorbs at most 2 words. IN_READY falls the cycle after the second acceptance.
- No combinational path from OUT_READY to IN_READY.

## Configuration
- MUX_SEL_PIPE_RANGE_CHECK_EN defined:
  - SEL_ERR port exists.
  - SEL_ERR sets on any input transfer with SELECT >= NUM_IN.
  - SEL_ERR clears only on RESET.
  - The data path still selects input 0.
- Not defined:
  - No SEL_ERR port.
  - Out-of-range selects silently pick input 0.
- The macro only has an effect when NUM_IN is not a power of two.

## Structure
- The shared CPU package holds the state encodings: EMPTY=2'b00, BUSY=2'b01, FULL=2'b10.
- Sub-module: mux_nx1, a purely combinational WIDTH x NUM_IN selector with default-to-input-0. It is instantiated once on the input side.
- The skid/state logic stays in mux_sel_pipe.

## Test plan
- Reset then stream: NUM_IN=4, inputs {A0,B1,C2,D3}, SELECT 2,0,3 on consecutive cycles, OUT_READY=1 -> OUT_DATA C2,A0,D3 on consecutive cycles, each 1 cycle after acceptance; OUT_SEL 2,0,3.
- Back-pressure: OUT_READY=0 for 4 cycles while IN_VALID=1 -> exactly 2 words accepted, IN_READY=0 from the third cycle; on release, both words emerge in order with no loss or duplicate.
- Flush while FULL: FLUSH=1 with IN_VALID=1 -> next cycle OUT_VALID=0, state EMPTY, IN_READY=1; the flush-cycle input never appears at the output.
- Out-of-range: NUM_IN=3, SELECT=3, IN0=0x1234 -> OUT_DATA=0x1234; with the macro defined, SEL_ERR=1 and it stays set until RESET.
- Reset mid-stream: assert RESET while FULL -> next cycle OUT_VALID=0, OUT_DATA=0, IN_READY=1; an input presented during RESET is not accepted.
- Width sweep: WIDTH=64, NUM_IN=8, all selects 0..7 -> OUT_DATA matches the indexed slice for each select.
